sram_like_axi_bridge: RTL
=========================

# sram_like_axi_bridge

Converts the CPU's two SRAM-like master ports (instruction, data) into a single AXI4 master port with one outstanding transaction. Sits directly downstream of the per-port `sram_like_handshake` request generators and is the only block in the core that drives the external AXI bus. Arbitrates between ports with fixed data-port priority, issues single-beat AXI transfers, and returns completion as a one-cycle `data_ok` pulse on the port that owns the transaction.

## Interface
Parameters:
- `AXI_ID_INST`, 4'd0, ARID/AWID used for instruction-port transactions
- `AXI_ID_DATA`, 4'd1, ARID/AWID used for data-port transactions

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock
- `rst` in 1 — synchronous active-high reset
- `inst_req`/`data_req` in 1 — request valid per port
- `inst_wr`/`data_wr` in 1 — 1 = write
- `inst_size`/`data_size` in 2 — 0 byte, 1 half, 2 word (3 treated as 2)
- `inst_addr`/`data_addr` in 32 — byte address
- `inst_wdata`/`data_wdata` in 32 — write data, byte lanes already aligned
- `inst_addr_ok`/`data_addr_ok` out 1 — request accepted this cycle
- `inst_data_ok`/`data_data_ok` out 1 — one-cycle completion pulse
- `inst_rdata`/`data_rdata` out 32 — read data, valid when `*_data_ok`
- AXI AR: `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1
- AXI R: `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1
- AXI AW: `awid` out 4, `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awvalid` out 1, `awready` in 1
- AXI W: `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1
- AXI B: `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: if `data_req`, grant data port; else if `inst_req`, grant inst port. Granting asserts that port's `*_addr_ok` combinationally in the same cycle and latches wr, size, addr, wdata, owner. Next state RD_ADDR (read) or WR_REQ (write). The non-granted port sees `addr_ok`=0 and must hold its request.
- RD_ADDR: `arvalid`=1 with latched fields; on `arready` go to RD_DATA.
- RD_DATA: `rready`=1; on `rvalid`: owner's `*_data_ok`=1 and `*_rdata`=`rdata` in the same cycle; go to IDLE.
- WR_REQ: `awvalid` and `wvalid` raised together and dropped independently as each handshakes (tracked by two done flags); when both have handshaked, go to WR_RESP. Both may handshake in the same cycle.
- WR_RESP: `bready`=1; on `bvalid` go to IDLE (completion per Configuration).
- Fixed fields: `arlen`=`awlen`=0, `arburst`=`awburst`=2'b01, `wlast`=1, `a*size`={1'b0,size} with size 3 mapped to 3'b010, address passed unaligned-unmodified.
- `wstrb`: size 0 → 4'b0001<<addr[1:0]; size 1 → 4'b0011<<{addr[1],1'b0}; size 2/3 → 4'b1111.
- `rresp`, `bresp`, `rid`, `bid` ignored (no error reporting). `*_rdata` held at last value when not pulsing.
- `addr_ok` and `data_ok` are never asserted in the same cycle; a new grant occurs no earlier than the cycle after `data_ok`.

## Timing
- Reset: state IDLE; all `*valid`, `rready`, `bready`, `*_addr_ok`, `*_data_ok` = 0; `*_rdata` = 0; latched fields = 0.
- Reset mid-transaction abandons it: no `data_ok` is ever generated for it.
- Minimum read: grant cycle T, `arvalid` T+1, `arready` T+1 → `data_ok` at T+2 if `rvalid` at T+2.
- Minimum write (with macro): grant T, AW/W handshake T+1, B at T+2 → `data_ok` T+2.
- AXI valid signals, once high, stay high and stable until their ready.

## Configuration
- `BRIDGE_WRITE_RESP_WAIT_EN` defined: write `data_ok` pulses in the WR_RESP cycle where `bvalid` is seen.
- Undefined: write `data_ok` pulses in the cycle the last of AW/W handshakes completes (early ack); WR_RESP still waits for `bvalid` before IDLE, so no new grant before B.

## Test plan
- Data read, addr 0x1000_0004 size 2, slave `arready`=1, `rvalid` next cycle with rdata 0xDEADBEEF → `data_addr_ok` T, `araddr`=0x1000_0004 `arsize`=2 `arid`=1, `data_data_ok`=1 with `data_rdata`=0xDEADBEEF at T+2.
- Both ports request in same cycle (inst read 0xBFC0_0000, data read 0x8000_0000) → data granted first; inst granted the cycle after data's `data_ok`, `arid`=0.
- Byte write addr 0x8000_0003 wdata 0xAA00_0000 → `wstrb`=4'b1000, `awsize`=0; `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` held 4 cycles.
- Half write addr 0x8000_0002: with `BRIDGE_WRITE_RESP_WAIT_EN` → `data_ok` on `bvalid` cycle; without → `data_ok` on AW/W completion, `wstrb`=4'b1100 both builds.
- `rst` asserted while in RD_DATA → next cycle all outputs at reset values; a later `rvalid` produces no `data_ok`.

Source files
------------

// File: rtl/sram_like_axi_bridge.sv
// sram_like_axi_bridge: merges the instruction and data SRAM-like ports onto a
// single AXI4 master with one outstanding single-beat transaction. The data
// port has fixed priority over the instruction port.
// Optional feature macro: BRIDGE_WRITE_RESP_WAIT_EN. When defined, a write's
// data_ok waits for the B response; otherwise it pulses once AW and W are done.
module sram_like_axi_bridge #(
  parameter logic [3:0] AXI_ID_INST = 4'd0,
  parameter logic [3:0] AXI_ID_DATA = 4'd1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_req_i,
  input  logic        inst_wr_i,
  input  logic [1:0]  inst_size_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_wdata_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [7:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;          // 1 = data port owns the transaction
  logic [1:0]      size_q, size_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DW-1:0]   data_rdata_q, data_rdata_d;
  logic            rd_done, wr_done, aw_fin, w_fin;
  logic [2:0]      axsize;
  logic            unused_ok;

  // Response ID/status fields carry no information this bridge acts on.
  assign unused_ok = ^{rid_i, rresp_i, rlast_i, bid_i, bresp_i};

  // State and latched request fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Next-state, grant and handshake control.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    size_d         = size_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    inst_addr_ok_o = 1'b0;
    data_addr_ok_o = 1'b0;
    arvalid_o      = 1'b0;
    rready_o       = 1'b0;
    awvalid_o      = 1'b0;
    wvalid_o       = 1'b0;
    bready_o       = 1'b0;
    rd_done        = 1'b0;
    wr_done        = 1'b0;
    aw_fin         = 1'b0;
    w_fin          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rst_i && data_req_i) begin
          data_addr_ok_o = 1'b1;
          owner_d        = 1'b1;
          size_d         = data_size_i;
          addr_d         = data_addr_i;
          wdata_d        = data_wdata_i;
          state_d        = data_wr_i ? S_WR_REQ : S_RD_ADDR;
        end else if (!rst_i && inst_req_i) begin
          inst_addr_ok_o = 1'b1;
          owner_d        = 1'b0;
          size_d         = inst_size_i;
          addr_d         = inst_addr_i;
          wdata_d        = inst_wdata_i;
          state_d        = inst_wr_i ? S_WR_REQ : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          rd_done = !rst_i;
          state_d = S_IDLE;
          if (owner_q) data_rdata_d = rdata_i;
          else         inst_rdata_d = rdata_i;
        end
      end
      S_WR_REQ: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        aw_fin    = aw_done_q | awready_i;
        w_fin     = w_done_q | wready_i;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          state_d   = S_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifndef BRIDGE_WRITE_RESP_WAIT_EN
          wr_done   = !rst_i;
`endif
        end
      end
      S_WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          state_d = S_IDLE;
`ifdef BRIDGE_WRITE_RESP_WAIT_EN
          wr_done = !rst_i;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Completion pulses; read data bypasses the holding register on the pulse.
  assign inst_data_ok_o = (rd_done | wr_done) & !owner_q;
  assign data_data_ok_o = (rd_done | wr_done) & owner_q;
  assign inst_rdata_o   = (rd_done && !owner_q) ? rdata_i : inst_rdata_q;
  assign data_rdata_o   = (rd_done && owner_q)  ? rdata_i : data_rdata_q;

  // Fixed single-beat INCR fields driven from the latched request.
  assign axsize    = (size_q == 2'd3) ? 3'b010 : {1'b0, size_q};
  assign arid_o    = owner_q ? AXI_ID_DATA : AXI_ID_INST;
  assign awid_o    = owner_q ? AXI_ID_DATA : AXI_ID_INST;
  assign araddr_o  = addr_q;
  assign awaddr_o  = addr_q;
  assign arsize_o  = axsize;
  assign awsize_o  = axsize;
  assign arlen_o   = 8'd0;
  assign awlen_o   = 8'd0;
  assign arburst_o = 2'b01;
  assign awburst_o = 2'b01;
  assign wdata_o   = wdata_q;
  assign wlast_o   = 1'b1;

  // Byte strobes from size and low address bits.
  always_comb begin
    unique case (size_q)
      2'd0:    wstrb_o = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb_o = 4'b0011 << {addr_q[1], 1'b0};
      default: wstrb_o = 4'b1111;
    endcase
  end

endmodule
